// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of an asynchronous divided clock
// in system clock cycles, tracks divisor stability (locked) and flags missing edges
// (timeout). Optional duty measurement is built when CLKMEAS_DUTY_EN is defined;
// otherwise high_out is tied to 0.
module clk_period_meter #(
  parameter int unsigned W        = 8,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sig_in,
  output logic [W-1:0] period_out,
  output logic [W-1:0] high_out,
  output logic         meas_valid,
  output logic         locked,
  output logic         timeout
);

  typedef enum logic [0:0] {StIdle, StMeas} state_e;

  localparam logic [W-1:0] CntMax = {W{1'b1}};
  localparam logic [3:0]   RunMax = 4'(LOCK_CNT);

  logic           s1_q, s2_q, s3_q;
  logic           rise;
  state_e         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   period_q, period_d;
  logic           valid_q, valid_d;
  logic           locked_q, locked_d;
  logic           timeout_q, timeout_d;
  logic [3:0]     run_q, run_d;

  assign rise = s2_q & ~s3_q;

  // Synchronizer plus history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Period counter, capture, lock tracking and timeout next-state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    run_d     = run_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        // First edge only starts the count; it carries no period
        if (rise) begin
          cnt_d   = W'(1);
          state_d = StMeas;
        end
      end
      StMeas: begin
        cnt_d = cnt_q + W'(1);
        if (rise) begin
          cnt_d     = W'(1);
          period_d  = cnt_q;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          if (cnt_q == period_q) begin
            run_d = (run_q >= RunMax) ? RunMax : run_q + 4'd1;
          end else begin
            run_d = 4'd1;
          end
          locked_d = (run_d == RunMax);
        end else if (cnt_q == CntMax) begin
          // Rise has priority; only an edge-less full count times out
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          run_d     = '0;
          cnt_d     = '0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Measurement state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
      run_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
      run_q     <= run_d;
    end
  end

`ifdef CLKMEAS_DUTY_EN
  logic         fall;
  logic         fall_seen_q, fall_seen_d;
  logic [W-1:0] hcnt_q, hcnt_d;
  logic [W-1:0] high_q, high_d;

  assign fall = ~s2_q & s3_q;

  // High-time counter: counts only until the first fall after a rise
  always_comb begin
    hcnt_d      = hcnt_q;
    high_d      = high_q;
    fall_seen_d = fall_seen_q;
    if (rise) begin
      if (state_q == StMeas) high_d = hcnt_q;
      hcnt_d      = W'(1);
      fall_seen_d = 1'b0;
    end else if (state_q == StMeas) begin
      if (s2_q && !fall_seen_q) hcnt_d = hcnt_q + W'(1);
      if (fall) fall_seen_d = 1'b1;
    end
  end

  // High-time state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q      <= '0;
      high_q      <= '0;
      fall_seen_q <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      high_q      <= high_d;
      fall_seen_q <= fall_seen_d;
    end
  end

  assign high_out = high_q;
`else
  assign high_out = '0;
`endif

  assign period_out = period_q;
  assign meas_valid = valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule
